// File: rtl/tick_rr_arbiter_if.sv
// Handshake bundle between requesters (master) and tick_rr_arbiter (slave).
// drop_cnt exists only when TICK_DROP_CNT_EN is defined.
interface tick_rr_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0] req_tick;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_id;
   logic            active;
   logic [NREQ-1:0] pend;
`ifdef TICK_DROP_CNT_EN
   logic [7:0]      drop_cnt;

   modport master (output req_tick, input grant, grant_id, active, pend, drop_cnt);
   modport slave  (input req_tick, output grant, grant_id, active, pend, drop_cnt);
`else
   modport master (output req_tick, input grant, grant_id, active, pend);
   modport slave  (input req_tick, output grant, grant_id, active, pend);
`endif
endinterface

// File: rtl/tick_rr_arbiter.sv
// Round-robin arbiter for one-cycle button ticks: latch, grant for HOLD cycles, one-cycle gap.
// Optional TICK_DROP_CNT_EN adds a saturating count of ticks absorbed by already-pending requests.
module tick_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int HOLD = 3,
   parameter int CW   = 4
) (
   input  logic              slowClk,
   input  logic              reset,
   tick_rr_arbiter_if.slave  bus
);
   localparam int             HOLD_E = (HOLD < 1) ? 1 : HOLD;
   localparam logic [CW-1:0]  LOAD   = CW'(HOLD_E - 1);
   localparam logic [IDW-1:0] LAST0  = IDW'(NREQ - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [IDW-1:0]  last_id;
   logic            win_found;
   logic [IDW-1:0]  win_id;
   logic [NREQ-1:0] win_oh;
   logic [NREQ-1:0] clr;
   logic            can_grant;

   // Walk from farthest to nearest so the nearest pending index after last_id wins.
   always_comb begin
      int idx;
      win_found = 1'b0;
      win_id    = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = (int'(last_id) + k) % NREQ;
         if (bus.pend[idx[IDW-1:0]]) begin
            win_found = 1'b1;
            win_id    = idx[IDW-1:0];
         end
      end
   end

   assign win_oh    = {{(NREQ-1){1'b0}}, 1'b1} << win_id;
   assign can_grant = ((state == IDLE) || (state == GAP)) && win_found;
   assign clr       = can_grant ? win_oh : '0;

   always_ff @(posedge slowClk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         last_id      <= LAST0;
         bus.grant    <= '0;
         bus.grant_id <= '0;
         bus.active   <= 1'b0;
         bus.pend     <= '0;
      end else begin
         // A fresh tick re-sets the bit being cleared, so a same-edge request is kept.
         bus.pend <= (bus.pend & ~clr) | bus.req_tick;
         case (state)
            IDLE, GAP: begin
               if (win_found) begin
                  state        <= GRANT;
                  bus.grant    <= win_oh;
                  bus.grant_id <= win_id;
                  bus.active   <= 1'b1;
                  cnt          <= LOAD;
                  last_id      <= win_id;
               end else begin
                  state      <= IDLE;
                  bus.grant  <= '0;
                  bus.active <= 1'b0;
               end
            end
            GRANT: begin
               if (cnt == '0) begin
                  state      <= GAP;
                  bus.grant  <= '0;
                  bus.active <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               bus.grant  <= '0;
               bus.active <= 1'b0;
               cnt        <= '0;
            end
         endcase
      end
   end

`ifdef TICK_DROP_CNT_EN
   logic drop_any;
   assign drop_any = |(bus.req_tick & bus.pend);

   always_ff @(posedge slowClk or posedge reset) begin
      if (reset)
         bus.drop_cnt <= '0;
      else if (drop_any && (bus.drop_cnt != 8'hFF))
         bus.drop_cnt <= bus.drop_cnt + 8'd1;
   end
`endif
endmodule

// File: tb/tb_tick_rr_arbiter.sv
// Directed bench for tick_rr_arbiter (NREQ=4, HOLD=3); drop counter checks run when TICK_DROP_CNT_EN is defined.
module tb_tick_rr_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic slowClk = 1'b0;
   logic reset   = 1'b1;
   int   errors  = 0;
   int   checks  = 0;

   always #5 slowClk = ~slowClk;

   tick_rr_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   tick_rr_arbiter #(.NREQ(NREQ), .IDW(IDW), .HOLD(3), .CW(4)) dut (
      .slowClk (slowClk),
      .reset   (reset),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) @(negedge slowClk);
   endtask

   task automatic chk_g(input string tag, input logic [3:0] exp, input logic [1:0] id);
      chk({tag, "_grant"}, 32'(bus.grant), 32'(exp));
      chk({tag, "_active"}, 32'(bus.active), 32'(exp != 4'd0));
      if (exp != 4'd0) chk({tag, "_id"}, 32'(bus.grant_id), 32'(id));
   endtask

   task automatic do_reset;
      bus.req_tick = '0;
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
   endtask

   initial begin
      logic [3:0] exp;
      bus.req_tick = '0;
      cyc(1);

      // single tick on requester 0
      do_reset();
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_id", 32'(bus.grant_id), 32'd0);
      chk("rst_active", 32'(bus.active), 32'd0);
      chk("rst_pend", 32'(bus.pend), 32'd0);
      bus.req_tick = 4'b0001;
      cyc();
      bus.req_tick = '0;
      chk("t1_pend", 32'(bus.pend), 32'h1);
      chk("t1_nogrant", 32'(bus.grant), 32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk_g("t1", (i < 3) ? 4'b0001 : 4'b0000, 2'd0);
      end
      chk("t1_pend_clr", 32'(bus.pend), 32'd0);

      // all four tick together: 0,1,2,3 with one-cycle gaps
      do_reset();
      bus.req_tick = 4'b1111;
      cyc();
      bus.req_tick = '0;
      chk("t2_pend", 32'(bus.pend), 32'hF);
      for (int i = 0; i < 16; i++) begin
         cyc();
         exp = ((i % 4) < 3) ? (4'b0001 << (i / 4)) : 4'b0000;
         chk_g("t2", exp, 2'(i / 4));
      end
      cyc();
      chk("t2_pend_end", 32'(bus.pend), 32'd0);

      // 0101 arrives while 2 is granted: 0 next, then 2
      do_reset();
      bus.req_tick = 4'b0100;
      cyc();
      bus.req_tick = '0;
      cyc();
      chk_g("t3_g2", 4'b0100, 2'd2);
      bus.req_tick = 4'b0101;
      cyc();
      bus.req_tick = '0;
      cyc(2);
      chk_g("t3_gap", 4'b0000, 2'd0);
      chk("t3_pend_gap", 32'(bus.pend), 32'h5);
      cyc();
      chk_g("t3_g0", 4'b0001, 2'd0);
      chk("t3_pend_g0", 32'(bus.pend), 32'h4);
      cyc(4);
      chk_g("t3_g2b", 4'b0100, 2'd2);
      cyc(3);
      chk_g("t3_end", 4'b0000, 2'd0);
      chk("t3_pend_end", 32'(bus.pend), 32'd0);

      // tick on the grant edge stays queued and is served again
      do_reset();
      bus.req_tick = 4'b0010;
      cyc(2);
      bus.req_tick = '0;
      chk_g("t4_g1", 4'b0010, 2'd1);
      chk("t4_pend_kept", 32'(bus.pend), 32'h2);
`ifdef TICK_DROP_CNT_EN
      chk("t4_drop", 32'(bus.drop_cnt), 32'd1);
`endif
      cyc(3);
      chk_g("t4_gap", 4'b0000, 2'd0);
      cyc();
      chk_g("t4_g1b", 4'b0010, 2'd1);
      chk("t4_pend_clr", 32'(bus.pend), 32'd0);

      // async reset mid-grant
      do_reset();
      bus.req_tick = 4'b0100;
      cyc();
      bus.req_tick = 4'b1001;
      cyc();
      bus.req_tick = '0;
      chk_g("t5_g2", 4'b0100, 2'd2);
      chk("t5_pend", 32'(bus.pend), 32'h9);
      #2 reset = 1'b1;
      #1;
      chk("t5_rst_grant", 32'(bus.grant), 32'd0);
      chk("t5_rst_pend", 32'(bus.pend), 32'd0);
      chk("t5_rst_active", 32'(bus.active), 32'd0);
      chk("t5_rst_id", 32'(bus.grant_id), 32'd0);
      cyc();
      reset = 1'b0;
      bus.req_tick = 4'b1000;
      cyc();
      bus.req_tick = '0;
      cyc();
      chk_g("t5_g3", 4'b1000, 2'd3);

`ifdef TICK_DROP_CNT_EN
      // continuous tick on 0 keeps pend[0] set; every edge after the first is a drop
      do_reset();
      chk("t6_drop_rst", 32'(bus.drop_cnt), 32'd0);
      bus.req_tick = 4'b0001;
      for (int n = 1; n <= 300; n++) begin
         cyc();
         if (n == 101) chk("t6_drop_100", 32'(bus.drop_cnt), 32'd100);
         if (n == 256) chk("t6_drop_255", 32'(bus.drop_cnt), 32'd255);
      end
      chk("t6_drop_sat", 32'(bus.drop_cnt), 32'd255);
      bus.req_tick = '0;
      cyc(2);
      chk("t6_drop_hold", 32'(bus.drop_cnt), 32'd255);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
